// File: rtl/vcve2_vrf_mem.sv
// vcve2_vrf_mem: word-addressed vector register file storage shared by the vrf and lsu requesters
module vcve2_vrf_mem #(
  parameter int unsigned VLEN        = 128,
  parameter int unsigned NumRegs     = 32,
  parameter int unsigned ReadLatency = 1,
  parameter logic [31:0] BaseAddr    = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vrf_req_i,
  output logic        vrf_gnt_o,
  input  logic [31:0] vrf_addr_i,
  input  logic        vrf_we_i,
  input  logic [3:0]  vrf_be_i,
  input  logic [31:0] vrf_wdata_i,
  output logic        vrf_rvalid_o,
  output logic [31:0] vrf_rdata_o,
  output logic        vrf_err_o,
  input  logic        lsu_req_i,
  output logic        lsu_gnt_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o
);
  localparam int unsigned Words = NumRegs * VLEN / 32;
  localparam int unsigned AW    = $clog2(Words);
  localparam logic [31:0] Bytes = 32'(Words * 4);
  localparam int unsigned L     = ReadLatency - 1;

  logic            prio_lsu;
  logic            go;
  logic [31:0]     addr;
  logic [31:0]     off;
  logic [31:0]     wdata;
  logic            we;
  logic [3:0]      be;
  logic            err;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [Words];
  logic            pv [ReadLatency];
  logic            pp [ReadLatency];
  logic            pe [ReadLatency];
  logic [31:0]     pd [ReadLatency];

  // the non-priority port only wins when the priority port is idle; nothing is granted in reset
  assign vrf_gnt_o = !rst_i && vrf_req_i && (!lsu_req_i || !prio_lsu);
  assign lsu_gnt_o = !rst_i && lsu_req_i && (!vrf_req_i || prio_lsu);
  assign go    = vrf_gnt_o || lsu_gnt_o;
  assign addr  = lsu_gnt_o ? lsu_addr_i  : vrf_addr_i;
  assign wdata = lsu_gnt_o ? lsu_wdata_i : vrf_wdata_i;
  assign we    = lsu_gnt_o ? lsu_we_i    : vrf_we_i;
  assign be    = lsu_gnt_o ? lsu_be_i    : vrf_be_i;
  assign off   = addr - BaseAddr;
  assign err   = |off[1:0] || addr < BaseAddr || off >= Bytes;
  assign idx   = off[AW+1:2];

  // priority flips only on contended cycles, handing it to the loser
  always_ff @(posedge clk_i) begin
    if (rst_i) prio_lsu <= 1'b0;
    else if (vrf_req_i && lsu_req_i) prio_lsu <= !prio_lsu;
  end

  // byte-masked array write; erroneous transfers never touch the array
  always_ff @(posedge clk_i) begin
    if (go && we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  // fixed-latency response pipeline tagged with the originating port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ReadLatency); i++) begin
        pv[i] <= 1'b0;
        pp[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= go;
      pp[0] <= lsu_gnt_o;
      pe[0] <= go && err;
      pd[0] <= (go && !we && !err) ? mem[idx] : '0;
      for (int i = 1; i < int'(ReadLatency); i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign vrf_rvalid_o = !rst_i && pv[L] && !pp[L];
  assign lsu_rvalid_o = !rst_i && pv[L] && pp[L];
  assign vrf_rdata_o  = vrf_rvalid_o ? pd[L] : '0;
  assign lsu_rdata_o  = lsu_rvalid_o ? pd[L] : '0;
  assign vrf_err_o    = vrf_rvalid_o && pe[L];
  assign lsu_err_o    = lsu_rvalid_o && pe[L];
endmodule

// File: tb/tb_vcve2_vrf_mem.sv
// tb_vcve2_vrf_mem: directed vector bench for vcve2_vrf_mem at ReadLatency 1 and 3
module tb_vcve2_vrf_mem;
  logic clk = 1'b0;
  logic rst, rst3;
  always #5 clk = ~clk;

  logic vr, vw, lr, lw;
  logic [31:0] va, vd, la, ld;
  logic [3:0] vb, lb;
  logic gv, gl, rvv, rvl, ev, el;
  logic [31:0] rdv, rdl;

  logic xr, xw, yr, yw;
  logic [31:0] xa, xd, ya, yd;
  logic [3:0] xb, yb;
  logic xg, yg, xrv, yrv, xe, ye;
  logic [31:0] xrd, yrd;

  int checks = 0;
  int failures = 0;

  vcve2_vrf_mem dut (
    .clk_i(clk), .rst_i(rst),
    .vrf_req_i(vr), .vrf_gnt_o(gv), .vrf_addr_i(va), .vrf_we_i(vw), .vrf_be_i(vb),
    .vrf_wdata_i(vd), .vrf_rvalid_o(rvv), .vrf_rdata_o(rdv), .vrf_err_o(ev),
    .lsu_req_i(lr), .lsu_gnt_o(gl), .lsu_addr_i(la), .lsu_we_i(lw), .lsu_be_i(lb),
    .lsu_wdata_i(ld), .lsu_rvalid_o(rvl), .lsu_rdata_o(rdl), .lsu_err_o(el)
  );

  vcve2_vrf_mem #(.ReadLatency(3)) dut3 (
    .clk_i(clk), .rst_i(rst3),
    .vrf_req_i(xr), .vrf_gnt_o(xg), .vrf_addr_i(xa), .vrf_we_i(xw), .vrf_be_i(xb),
    .vrf_wdata_i(xd), .vrf_rvalid_o(xrv), .vrf_rdata_o(xrd), .vrf_err_o(xe),
    .lsu_req_i(yr), .lsu_gnt_o(yg), .lsu_addr_i(ya), .lsu_we_i(yw), .lsu_be_i(yb),
    .lsu_wdata_i(yd), .lsu_rvalid_o(yrv), .lsu_rdata_o(yrd), .lsu_err_o(ye)
  );

  typedef struct {
    logic vr; logic [31:0] va; logic vw; logic [3:0] vb; logic [31:0] vd;
    logic lr; logic [31:0] la; logic lw; logic [3:0] lb; logic [31:0] ld;
    logic gv; logic gl;
    logic rvv; logic [31:0] dv; logic ev;
    logic rvl; logic [31:0] dl; logic el;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(
    input logic a_vr, input logic [31:0] a_va, input logic a_vw, input logic [3:0] a_vb, input logic [31:0] a_vd,
    input logic a_lr, input logic [31:0] a_la, input logic a_lw, input logic [3:0] a_lb, input logic [31:0] a_ld,
    input logic a_gv, input logic a_gl,
    input logic a_rvv, input logic [31:0] a_dv, input logic a_ev,
    input logic a_rvl, input logic [31:0] a_dl, input logic a_el);
    vec_t t;
    t.vr = a_vr; t.va = a_va; t.vw = a_vw; t.vb = a_vb; t.vd = a_vd;
    t.lr = a_lr; t.la = a_la; t.lw = a_lw; t.lb = a_lb; t.ld = a_ld;
    t.gv = a_gv; t.gl = a_gl;
    t.rvv = a_rvv; t.dv = a_dv; t.ev = a_ev;
    t.rvl = a_rvl; t.dl = a_dl; t.el = a_el;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1,'h10,1,4'hF,'hDEADBEEF, 0,0,0,0,0,              1,0, 0,0,0,            0,0,0);
    tbl[1]  = mk(1,'h10,0,0,0,             0,0,0,0,0,              1,0, 1,0,0,            0,0,0);
    tbl[2]  = mk(1,'h10,1,4'h5,'h11223344, 0,0,0,0,0,              1,0, 1,'hDEADBEEF,0,   0,0,0);
    tbl[3]  = mk(1,'h10,0,0,0,             0,0,0,0,0,              1,0, 1,0,0,            0,0,0);
    tbl[4]  = mk(0,0,0,0,0,                1,'h0,1,4'hF,'hA5A5A5A5, 0,1, 1,'hDE22BE44,0,  0,0,0);
    tbl[5]  = mk(1,'h10,0,0,0,             1,'h20,1,4'hF,'hCAFEF00D,1,0, 0,0,0,           1,0,0);
    tbl[6]  = mk(1,'h0,0,0,0,              1,'h20,1,4'hF,'hCAFEF00D,0,1, 1,'hDE22BE44,0,  0,0,0);
    tbl[7]  = mk(1,'h0,0,0,0,              1,'h20,0,0,0,           1,0, 0,0,0,            1,0,0);
    tbl[8]  = mk(1,'h20,0,0,0,             1,'h20,0,0,0,           0,1, 1,'hA5A5A5A5,0,   0,0,0);
    tbl[9]  = mk(1,'h20,0,0,0,             0,0,0,0,0,              1,0, 0,0,0,            1,'hCAFEF00D,0);
    tbl[10] = mk(0,0,0,0,0,                1,'h202,1,4'hF,'h12345678,0,1, 1,'hCAFEF00D,0, 0,0,0);
    tbl[11] = mk(0,0,0,0,0,                1,'h200,1,4'hF,'h12345678,0,1, 0,0,0,          1,0,1);
    tbl[12] = mk(1,'h202,0,0,0,            0,0,0,0,0,              1,0, 0,0,0,            1,0,1);
    tbl[13] = mk(0,0,0,0,0,                1,'h0,0,0,0,            0,1, 1,0,1,            0,0,0);
    tbl[14] = mk(0,0,0,0,0,                0,0,0,0,0,              0,0, 0,0,0,            1,'hA5A5A5A5,0);
    tbl[15] = mk(1,'h10,0,0,0,             1,'h10,0,0,0,           1,0, 0,0,0,            0,0,0);
    tbl[16] = mk(0,0,0,0,0,                1,'h10,0,0,0,           0,1, 1,'hDE22BE44,0,   0,0,0);
    tbl[17] = mk(0,0,0,0,0,                0,0,0,0,0,              0,0, 0,0,0,            1,'hDE22BE44,0);

    rst = 1; rst3 = 1;
    vr = 1; va = 0; vw = 0; vb = 0; vd = 0;
    lr = 1; la = 0; lw = 0; lb = 0; ld = 0;
    xr = 1; xa = 0; xw = 0; xb = 0; xd = 0;
    yr = 0; ya = 0; yw = 0; yb = 0; yd = 0;
    next_cycle();
    @(negedge clk);
    chk("reset_gnt_vrf", gv, 0);
    chk("reset_gnt_lsu", gl, 0);
    chk("reset_gnt_l3", xg, 0);
    chk("reset_rvalid", {rvv, rvl, ev, el}, 0);
    chk("reset_rdata", rdv | rdl, 0);
    next_cycle();
    vr = 0; lr = 0; xr = 0; rst = 0; rst3 = 0;

    foreach (tbl[i]) begin
      vr = tbl[i].vr; va = tbl[i].va; vw = tbl[i].vw; vb = tbl[i].vb; vd = tbl[i].vd;
      lr = tbl[i].lr; la = tbl[i].la; lw = tbl[i].lw; lb = tbl[i].lb; ld = tbl[i].ld;
      @(negedge clk);
      chk($sformatf("row%0d_gnt_vrf", i), gv, tbl[i].gv);
      chk($sformatf("row%0d_gnt_lsu", i), gl, tbl[i].gl);
      chk($sformatf("row%0d_rvalid_vrf", i), rvv, tbl[i].rvv);
      chk($sformatf("row%0d_rdata_vrf", i), rdv, tbl[i].dv);
      chk($sformatf("row%0d_err_vrf", i), ev, tbl[i].ev);
      chk($sformatf("row%0d_rvalid_lsu", i), rvl, tbl[i].rvl);
      chk($sformatf("row%0d_rdata_lsu", i), rdl, tbl[i].dl);
      chk($sformatf("row%0d_err_lsu", i), el, tbl[i].el);
      next_cycle();
    end

    // reset restores vrf priority, then four contended cycles alternate grants
    rst = 1;
    vr = 0; lr = 0;
    next_cycle();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      vr = (k < 4); va = 'h10; vw = 0;
      lr = (k < 4); la = 'h0; lw = 0;
      @(negedge clk);
      chk($sformatf("rr%0d_gnt_vrf", k), gv, (k < 4) && (k % 2 == 0));
      chk($sformatf("rr%0d_gnt_lsu", k), gl, (k < 4) && (k % 2 == 1));
      chk($sformatf("rr%0d_rvalid_vrf", k), rvv, (k > 0) && ((k - 1) % 2 == 0));
      chk($sformatf("rr%0d_rdata_vrf", k), rdv, ((k > 0) && ((k - 1) % 2 == 0)) ? 32'hDE22BE44 : 32'h0);
      chk($sformatf("rr%0d_rvalid_lsu", k), rvl, (k > 0) && ((k - 1) % 2 == 1));
      chk($sformatf("rr%0d_rdata_lsu", k), rdl, ((k > 0) && ((k - 1) % 2 == 1)) ? 32'hA5A5A5A5 : 32'h0);
      next_cycle();
    end
    vr = 0; lr = 0;

    // lsu writes the last word of v31, vrf reads it the next cycle
    lr = 1; la = 'h1FC; lw = 1; lb = 4'hF; ld = 'h0BADF00D;
    @(negedge clk);
    chk("raw_gnt_lsu", gl, 1);
    next_cycle();
    lr = 0; lw = 0;
    vr = 1; va = 'h1FC; vw = 0;
    @(negedge clk);
    chk("raw_gnt_vrf", gv, 1);
    chk("raw_wr_rvalid", rvl, 1);
    chk("raw_wr_rdata", rdl, 0);
    next_cycle();
    vr = 0;
    @(negedge clk);
    chk("raw_rd_rvalid", rvv, 1);
    chk("raw_rd_rdata", rdv, 'h0BADF00D);
    chk("raw_rd_err", ev, 0);
    next_cycle();

    // latency 3: four writes then four back-to-back reads
    for (int c = 0; c < 12; c++) begin
      xr = (c < 8); xw = (c < 4); xb = 4'hF;
      xa = 32'((c % 4) * 4); xd = 32'h100 + 32'(c % 4);
      @(negedge clk);
      chk($sformatf("l3_c%0d_gnt", c), xg, c < 8);
      chk($sformatf("l3_c%0d_rvalid", c), xrv, (c >= 3) && (c <= 10));
      chk($sformatf("l3_c%0d_rdata", c), xrd, (c >= 7 && c <= 10) ? 32'h100 + 32'(c - 7) : 32'h0);
      next_cycle();
    end

    // latency 3: reset in the middle of a read burst drops the rest
    for (int c = 0; c < 10; c++) begin
      rst3 = (c == 4 || c == 5);
      xr = (c < 6); xw = 0; xa = 32'((c % 4) * 4);
      @(negedge clk);
      chk($sformatf("l3r_c%0d_gnt", c), xg, c < 4);
      chk($sformatf("l3r_c%0d_rvalid", c), xrv, c == 3);
      chk($sformatf("l3r_c%0d_rdata", c), xrd, (c == 3) ? 32'h100 : 32'h0);
      chk($sformatf("l3r_c%0d_lsu_rvalid", c), yrv, 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vcve2_vrf_mem.md
Name: vcve2_vrf_mem

Overview:
- Storage backend behind the vector register file interface: word-addressed SRAM model holding NumRegs vector registers of VLEN bits each.
- Serves two OBI-style requesters:
  - port vrf: the VRF interface FSM that fetches operands and writes results.
  - port lsu: the vector load/store path.
- Single-ported array, so a round-robin arbiter grants at most one access per cycle.
- Responses return through a fixed-latency pipeline, tagged back to the originating port.

Parameters:
- VLEN, 128, bits per vector register; multiple of 32.
- NumRegs, 32, number of vector registers.
- ReadLatency, 1, cycles from grant to rvalid; legal range 1..3.
- BaseAddr, 32'h0, byte address of word 0 of v0; 4-byte aligned.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- vrf_req_i  in  1  port vrf request.
- vrf_gnt_o  out  1  port vrf grant (combinational).
- vrf_addr_i  in  32  port vrf byte address.
- vrf_we_i  in  1  port vrf write enable.
- vrf_be_i  in  4  port vrf byte enables.
- vrf_wdata_i  in  32  port vrf write data.
- vrf_rvalid_o  out  1  port vrf response valid.
- vrf_rdata_o  out  32  port vrf read data.
- vrf_err_o  out  1  port vrf error, qualified by vrf_rvalid_o.
- lsu_req_i, lsu_gnt_o, lsu_addr_i, lsu_we_i, lsu_be_i, lsu_wdata_i, lsu_rvalid_o, lsu_rdata_o, lsu_err_o: same directions, widths and meanings for port lsu.

Behaviour:
- Clocking/reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- On reset:
  - All gnt/rvalid/err outputs are 0 and rdata outputs are 0.
  - The response pipeline is flushed; in-flight responses are dropped and never delivered.
  - Arbiter priority is set to vrf.
  - Array contents are not reset.
- Word count is NumRegs*VLEN/32. Word index = (addr - BaseAddr) >> 2.
- Register vN occupies word indices N*VLEN/32 .. (N+1)*VLEN/32-1.
- Handshake:
  - A requester holds req and its addr/we/be/wdata stable until gnt is seen high.
  - A transfer occurs in any cycle with req=1 and gnt=1.
  - gnt is combinational from the req inputs and the priority register.
- Arbitration:
  - Only one port requesting: that port is granted the same cycle.
  - Both requesting: the priority port is granted.
  - After any cycle where both ports request, priority moves to the port that was not granted.
  - Single-requester cycles leave priority unchanged.
  - Never both gnt high in one cycle.
- Error check at grant time. A transfer is an error when addr[1:0] != 0, or when addr < BaseAddr, or when addr >= BaseAddr + NumRegs*VLEN/8.
  - Error transfer: no array access; response has err=1, rdata=0.
- Write transfer:
  - Bytes with be[i]=1 are updated at the grant-cycle edge; be=0000 is a legal no-op.
  - Response has rdata=0, err=0.
- Read transfer:
  - Array word sampled at the grant-cycle edge.
  - A read granted the cycle after a write to the same word returns the new data.
- Response pipeline:
  - Depth ReadLatency, entries {valid, port, err, data}.
  - Granted in cycle t → rvalid=1 on the granted port only, in cycle t+ReadLatency, for exactly one cycle.
  - Responses on each port are returned in grant order.
  - Back-to-back grants give back-to-back rvalids.
- There is no response backpressure; the block accepts one transfer every cycle.
- rdata and err are 0 whenever the corresponding rvalid is 0.

Test Plan:
- vrf write 0xDEADBEEF, be=1111, addr 0x10 (v1 word0, VLEN=128); then read 0x10 → gnt same cycle; each rvalid 1 cycle after its grant; read rdata=0xDEADBEEF, err=0.
- Byte enables: vrf write 0x11223344 with be=0101 over existing 0xDEADBEEF at addr 0x10; read back → 0xDE22BE44.
- Both ports request every cycle for 4 cycles after reset → grants vrf, lsu, vrf, lsu; each rvalid appears on the matching port.
- Error transfers:
  - addr 0x202 → err=1, rdata=0, rvalid after ReadLatency.
  - addr 0x200 (just past 32x16 bytes) → err=1, rdata=0.
  - Array unchanged after an erroneous write.
- ReadLatency=3:
  - Four back-to-back vrf reads → rvalids in cycles t+3..t+6, in order.
  - Assert rst_i at t+4 → no further rvalid; gnt=0 while rst_i=1.
- Read-after-write: lsu write v31 last word (0x1FC) in cycle t, vrf read 0x1FC in cycle t+1 → vrf returns the written value.
